// File: rtl/priority_pkg.sv
// ----------------------------------------------------------------------------
// priority_pkg
// Shared definitions for the priority decoder slice.
//   state_e   : grant FSM state encoding (IDLE, GRANT)
//   idx_width : index width for an N-entry one-hot vector, floored at 1 bit.
//               It sizes the decoder index port and the grant hold counter.
// ----------------------------------------------------------------------------
package priority_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // Bits needed to encode 0..n-1; a single-entry vector still gets 1 bit
   function automatic int idx_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage : priority_pkg

// File: rtl/grant_timer.sv
// ----------------------------------------------------------------------------
// grant_timer
// Hold counter for an active grant. It counts cycles while enable is high.
// It saturates at TIMEOUT-1, so it never wraps.
// expired is high while the count sits at TIMEOUT-1, which is the last cycle
// the grant may be held.
//
// Ports
//   clk     in  : rising-edge clock
//   rst_n   in  : synchronous active-low reset (count -> 0)
//   clear   in  : force the count to 0 at the next edge (wins over enable)
//   enable  in  : advance the count by one at the next edge
//   expired out : count == TIMEOUT-1
// ----------------------------------------------------------------------------
module grant_timer
   import priority_pkg::*;
#(
   parameter  int TIMEOUT = 16,
   localparam int TW      = idx_width(TIMEOUT)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] count_r;
   logic [TW-1:0] count_nxt_s;

   // Next count: clear wins; otherwise step up, but never past LAST
   always_comb begin
      count_nxt_s = count_r;
      if (clear) begin
         count_nxt_s = {TW{1'b0}};
      end else if (enable && (count_r != LAST)) begin
         count_nxt_s = count_r + TW'(1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Count register with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_r <= {TW{1'b0}};
      end else begin
         count_r <= count_nxt_s;
      end
   end

   assign expired = (count_r == LAST);

endmodule : grant_timer

// File: rtl/priority_dec.sv
// ----------------------------------------------------------------------------
// priority_dec
// Decodes an encoded index into a registered one-hot grant. It holds the grant
// until the grantee acks on its own line or the hold timer expires.
// A grant end is always followed by one IDLE cycle, so the block accepts at
// most one index every two cycles.
//
// Ports
//   clk       in  : rising-edge clock
//   rst_n     in  : synchronous active-low reset
//   in_valid  in  : an index is offered
//   in_idx    in  : encoded index (W bits)
//   in_ready  out : state is IDLE (decoded from the state register)
//   gnt       out : registered one-hot grant, zero while IDLE
//   ack       in  : per-line completion from the grantee
//   done      out : one-cycle pulse, grant completed by ack
//   timeout   out : one-cycle pulse, grant dropped after TIMEOUT cycles
//   err       out : one-cycle pulse, illegal index or ack on a non-granted line
// ----------------------------------------------------------------------------
module priority_dec
   import priority_pkg::*;
#(
   parameter  int N       = 8,
   parameter  int TIMEOUT = 16,
   localparam int W       = idx_width(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [W-1:0] in_idx,
   output logic         in_ready,
   output logic [N-1:0] gnt,
   input  logic [N-1:0] ack,
   output logic         done,
   output logic         timeout,
   output logic         err
);

   // N as a W+1 bit value, so a power-of-two N stays comparable with in_idx
   localparam logic [W:0] N_L = (W + 1)'(N);

   state_e       state_r;
   state_e       state_nxt_s;
   logic [W-1:0] idx_r;
   logic [W-1:0] idx_nxt_s;
   logic [N-1:0] gnt_r;
   logic [N-1:0] gnt_nxt_s;
   logic         done_r;
   logic         done_nxt_s;
   logic         timeout_r;
   logic         timeout_nxt_s;
   logic         err_r;
   logic         err_nxt_s;

   logic         idx_legal_s;
   logic         valid_ack_s;
   logic         spurious_s;
   logic         timer_clear_s;
   logic         timer_enable_s;
   logic         expired_s;

   assign idx_legal_s = ({1'b0, in_idx} < N_L);

   // Valid ack: the latched line acks while a grant is held
   assign valid_ack_s = (state_r == GRANT) && ack[idx_r];

   // gnt_r is zero in IDLE, so any ack bit there counts as spurious
   assign spurious_s  = |(ack & ~gnt_r);

   // Timer is held at zero outside GRANT; this also clears it at accept.
   // It stops counting on the edge a valid ack ends the grant.
   assign timer_clear_s  = (state_r != GRANT);
   assign timer_enable_s = (state_r == GRANT) && !valid_ack_s;

   grant_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_grant_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (timer_clear_s),
      .enable  (timer_enable_s),
      .expired (expired_s)
   );

   // Next state and next registered outputs; pulses default low
   always_comb begin
      state_nxt_s   = state_r;
      idx_nxt_s     = idx_r;
      gnt_nxt_s     = gnt_r;
      done_nxt_s    = 1'b0;
      timeout_nxt_s = 1'b0;
      err_nxt_s     = spurious_s;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               if (idx_legal_s) begin
                  state_nxt_s = GRANT;
                  idx_nxt_s   = in_idx;
                  gnt_nxt_s   = {{(N-1){1'b0}}, 1'b1} << in_idx;
               end else begin
                  err_nxt_s   = 1'b1;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         GRANT: begin
            // A valid ack wins over expiry on the same edge
            if (valid_ack_s) begin
               state_nxt_s = IDLE;
               gnt_nxt_s   = {N{1'b0}};
               done_nxt_s  = 1'b1;
            end else if (expired_s) begin
               state_nxt_s   = IDLE;
               gnt_nxt_s     = {N{1'b0}};
               timeout_nxt_s = 1'b1;
            end else begin
               state_nxt_s = GRANT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            gnt_nxt_s   = {N{1'b0}};
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         idx_r     <= {W{1'b0}};
         gnt_r     <= {N{1'b0}};
         done_r    <= 1'b0;
         timeout_r <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         idx_r     <= idx_nxt_s;
         gnt_r     <= gnt_nxt_s;
         done_r    <= done_nxt_s;
         timeout_r <= timeout_nxt_s;
         err_r     <= err_nxt_s;
      end
   end

   assign in_ready = (state_r == IDLE);
   assign gnt      = gnt_r;
   assign done     = done_r;
   assign timeout  = timeout_r;
   assign err      = err_r;

endmodule : priority_dec

// File: tb/tb_priority_dec.sv
// ----------------------------------------------------------------------------
// tb_priority_dec
// Self-checking bench for priority_dec (N=8, TIMEOUT=4).
// A transaction-level reference model tracks the granted line and its age as
// integers. Directed scenarios are followed by randomized traffic.
// A second instance with N=6 covers the illegal-index case.
// ----------------------------------------------------------------------------
module tb_priority_dec;

   localparam int N  = 8;
   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [2:0] in_idx;
   logic       in_ready;
   logic [7:0] gnt;
   logic [7:0] ack;
   logic       done;
   logic       timeout;
   logic       err;

   logic       in_valid6;
   logic [2:0] in_idx6;
   logic       in_ready6;
   logic [5:0] gnt6;
   logic [5:0] ack6;
   logic       done6;
   logic       timeout6;
   logic       err6;

   always #5 clk = ~clk;

   priority_dec #(.N(8), .TIMEOUT(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_idx   (in_idx),
      .in_ready (in_ready),
      .gnt      (gnt),
      .ack      (ack),
      .done     (done),
      .timeout  (timeout),
      .err      (err)
   );

   priority_dec #(.N(6), .TIMEOUT(4)) dut6 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid6),
      .in_idx   (in_idx6),
      .in_ready (in_ready6),
      .gnt      (gnt6),
      .ack      (ack6),
      .done     (done6),
      .timeout  (timeout6),
      .err      (err6)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: m_cur = granted line (-1 when none), m_age = grant cycles elapsed
   int   m_cur = -1;
   int   m_age = 0;
   logic m_done;
   logic m_to;
   logic m_err;

   task automatic model(input logic r, input logic v, input int idx, input logic [7:0] a);
      logic [7:0] line;
      m_done = 1'b0;
      m_to   = 1'b0;
      if (m_cur < 0) begin
         m_err = (a != 8'h00);
      end else begin
         line  = 8'h01 << m_cur;
         m_err = ((a & ~line) != 8'h00);
      end
      if (!r) begin
         m_cur = -1;
         m_age = 0;
         m_err = 1'b0;
      end else if (m_cur < 0) begin
         if (v) begin
            if (idx < N) begin
               m_cur = idx;
               m_age = 1;
            end else begin
               m_err = 1'b1;
            end
         end
      end else if (a[m_cur]) begin
         m_done = 1'b1;
         m_cur  = -1;
      end else if (m_age == TO) begin
         m_to  = 1'b1;
         m_cur = -1;
      end else begin
         m_age++;
      end
   endtask

   task automatic step(input logic r, input logic v, input int idx, input logic [7:0] a);
      logic [31:0] exp_gnt;
      rst_n    = r;
      in_valid = v;
      in_idx   = idx[2:0];
      ack      = a;
      model(r, v, idx, a);
      @(posedge clk);
      #1;
      exp_gnt = (m_cur < 0) ? 32'h0 : (32'h1 << m_cur);
      check("gnt",      {24'h0, gnt}, exp_gnt);
      check("in_ready", {31'h0, in_ready}, {31'h0, (m_cur < 0)});
      check("done",     {31'h0, done}, {31'h0, m_done});
      check("timeout",  {31'h0, timeout}, {31'h0, m_to});
      check("err",      {31'h0, err}, {31'h0, m_err});
   endtask

   initial begin
      logic [7:0] a;
      int         sel;
      in_valid6 = 1'b0;
      in_idx6   = 3'd0;
      ack6      = 6'h00;

      // Reset, then first cycle after reset must be ready
      step(1'b0, 1'b0, 0, 8'h00);
      step(1'b0, 1'b0, 0, 8'h00);
      check("rst_ready", {31'h0, in_ready}, 32'h1);
      step(1'b1, 1'b0, 0, 8'h00);

      // N=6 instance: illegal index 6
      in_valid6 = 1'b1;
      in_idx6   = 3'd6;
      step(1'b1, 1'b0, 0, 8'h00);
      check("n6_err",   {31'h0, err6}, 32'h1);
      check("n6_gnt",   {26'h0, gnt6}, 32'h0);
      check("n6_ready", {31'h0, in_ready6}, 32'h1);
      in_valid6 = 1'b0;
      step(1'b1, 1'b0, 0, 8'h00);
      check("n6_err_1cyc", {31'h0, err6}, 32'h0);
      in_valid6 = 1'b1;
      in_idx6   = 3'd5;
      step(1'b1, 1'b0, 0, 8'h00);
      in_valid6 = 1'b0;
      check("n6_gnt5",  {26'h0, gnt6}, 32'h20);
      check("n6_busy",  {31'h0, in_ready6}, 32'h0);
      ack6 = 6'h20;
      step(1'b1, 1'b0, 0, 8'h00);
      ack6 = 6'h00;
      check("n6_done",  {31'h0, done6}, 32'h1);

      // idx 5, ack two cycles later
      step(1'b1, 1'b1, 5, 8'h00);
      check("d5_gnt", {24'h0, gnt}, 32'h20);
      step(1'b1, 1'b0, 0, 8'h00);
      step(1'b1, 1'b0, 0, 8'h20);
      check("d5_done", {31'h0, done}, 32'h1);
      check("d5_gnt0", {24'h0, gnt}, 32'h0);
      step(1'b1, 1'b0, 0, 8'h00);

      // idx 3, never acked: held 4 cycles then timeout
      step(1'b1, 1'b1, 3, 8'h00);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 0, 8'h00);
         check("d3_held", {24'h0, gnt}, 32'h08);
      end
      step(1'b1, 1'b0, 0, 8'h00);
      check("d3_timeout", {31'h0, timeout}, 32'h1);
      check("d3_gnt0", {24'h0, gnt}, 32'h0);
      step(1'b1, 1'b0, 0, 8'h00);

      // idx 0, ack in the expiry cycle: ack wins
      step(1'b1, 1'b1, 0, 8'h00);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 8'h00);
      step(1'b1, 1'b0, 0, 8'h01);
      check("d0_done", {31'h0, done}, 32'h1);
      check("d0_no_to", {31'h0, timeout}, 32'h0);
      step(1'b1, 1'b0, 0, 8'h00);

      // idx 2, spurious ack then valid ack; then both at once
      step(1'b1, 1'b1, 2, 8'h00);
      step(1'b1, 1'b0, 0, 8'h10);
      check("d2_err", {31'h0, err}, 32'h1);
      check("d2_held", {24'h0, gnt}, 32'h04);
      step(1'b1, 1'b0, 0, 8'h04);
      check("d2_done", {31'h0, done}, 32'h1);
      step(1'b1, 1'b1, 2, 8'h00);
      step(1'b1, 1'b0, 0, 8'h84);
      check("d2_both_done", {31'h0, done}, 32'h1);
      check("d2_both_err", {31'h0, err}, 32'h1);
      step(1'b1, 1'b0, 0, 8'h01);
      check("idle_ack_err", {31'h0, err}, 32'h1);

      // idx 7, reset mid-grant
      step(1'b1, 1'b1, 7, 8'h00);
      step(1'b1, 1'b0, 0, 8'h00);
      step(1'b0, 1'b0, 0, 8'h00);
      check("d7_gnt0", {24'h0, gnt}, 32'h0);
      check("d7_no_done", {31'h0, done}, 32'h0);
      check("d7_no_to", {31'h0, timeout}, 32'h0);
      step(1'b1, 1'b0, 0, 8'h00);
      check("d7_ready", {31'h0, in_ready}, 32'h1);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         sel = $urandom_range(0, 9);
         a   = 8'h00;
         if ((sel == 6 || sel == 7) && m_cur >= 0) begin
            a = 8'h01 << m_cur;
         end else if (sel == 8) begin
            a = 8'h01 << $urandom_range(0, 7);
         end else if (sel == 9) begin
            a = (8'h01 << $urandom_range(0, 7));
            if (m_cur >= 0) a = a | (8'h01 << m_cur);
         end
         step(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)),
              $urandom_range(0, 7), a);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_priority_dec
